// File: rtl/mult_arb_pkg.sv
// Shared types, default parameters and the round-robin pick helper for mult_arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MUL_LAT = 0;
  localparam int MAX_REQ     = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Searches from last+1 upward with wrap-around; n is the live requester count.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0] last,
                                    input int n);
    pick_t      r;
    logic [3:0] sum;
    logic [2:0] cand;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      sum  = {1'b0, last} + 4'(k);
      cand = 3'(sum % 4'(n));
      if (k <= n && !r.found && valid[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side request/response handshake bundle for mult_arbiter.
interface mult_arbiter_if import mult_arb_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       resp_valid;
  logic [N_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]       resp_y;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_y
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus winner index.
module rr_arbiter import mult_arb_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid), 3'(last_grant), N_REQ);
    grant = '0;
    idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick.idx == 3'(j)) begin
        idx      = IDX_W'(j);
        grant[j] = enable && pick.found;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external multiplier between N_REQ requesters, one transaction in flight,
// round-robin fairness, with a fixed multiplier latency of MUL_LAT cycles.
module mult_arbiter import mult_arb_pkg::*; #(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  mult_arbiter_if.slave    bus,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_y,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy
);

  localparam int CNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [CNT_W-1:0] counter;
  logic [N_REQ-1:0] resp_valid_q;
  logic [WIDTH-1:0] resp_y_q;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Gating with rst keeps req_ready low for the whole time reset is held.
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .enable     ((state == IDLE) && rst),
    .grant      (grant),
    .idx        (win_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_a = bus.req_a[i*WIDTH +: WIDTH];
        sel_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = resp_y_q;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(N_REQ - 1);
      counter      <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      grant_id     <= '0;
      resp_valid_q <= '0;
      resp_y_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            mul_a    <= sel_a;
            mul_b    <= sel_b;
            grant_id <= win_idx;
            counter  <= CNT_W'(MUL_LAT);
            state    <= MUL;
          end
        end
        MUL: begin
          if (counter != '0) begin
            counter <= counter - CNT_W'(1);
          end else begin
            resp_y_q     <= mul_y;
            resp_valid_q <= N_REQ'(1) << grant_id;
            state        <= RESP;
          end
        end
        RESP: begin
          // Only the owner's resp_ready can retire the transaction.
          if (bus.resp_ready[grant_id]) begin
            resp_valid_q <= '0;
            last_grant   <= grant_id;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench: a combinational-multiplier instance and a
// three-stage pipelined-multiplier instance, driven from hand-computed vectors.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;
  int cycle_count  = 0;
  int prev_cycle   = 0;

  mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus0 ();
  mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus3 ();

  logic [W-1:0] mul_a0, mul_b0, mul_y0;
  logic [W-1:0] mul_a3, mul_b3, mul_y3;
  logic [1:0]   grant_id0, grant_id3;
  logic         busy0, busy3;
  logic [W-1:0] pipe1, pipe2, pipe3;

  mult_arbiter #(.N_REQ(N), .WIDTH(W), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_y(mul_y0),
    .grant_id(grant_id0), .busy(busy0)
  );

  mult_arbiter #(.N_REQ(N), .WIDTH(W), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave),
    .mul_a(mul_a3), .mul_b(mul_b3), .mul_y(mul_y3),
    .grant_id(grant_id3), .busy(busy3)
  );

  // Multiplier models: one combinational, one with three register stages.
  assign mul_y0 = W'(mul_a0 * mul_b0);
  always @(posedge clk) begin
    pipe1 <= W'(mul_a3 * mul_b3);
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end
  assign mul_y3 = pipe3;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit on3, input logic [N-1:0] valid, input int slot,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    if (on3) begin
      bus3.req_a[slot*W +: W] = a;
      bus3.req_b[slot*W +: W] = b;
      bus3.req_valid          = valid;
    end else begin
      bus0.req_a[slot*W +: W] = a;
      bus0.req_b[slot*W +: W] = b;
      bus0.req_valid          = valid;
    end
  endtask

  // Called at a negedge in IDLE with the request set up and resp_ready high.
  task automatic serveTxn0(input string tag, input int id, input logic [W-1:0] y);
    #1 checkOutput({tag, "_ready"}, 64'(bus0.req_ready), 64'(1 << id));
    @(negedge clk);
    bus0.req_valid[id] = 1'b0;
    #1 checkOutput({tag, "_gid"}, 64'(grant_id0), 64'(id));
    @(negedge clk);
    #1 checkOutput({tag, "_rvalid"}, 64'(bus0.resp_valid), 64'(1 << id));
    checkOutput({tag, "_y"}, 64'(bus0.resp_y), 64'(y));
    @(negedge clk);
  endtask

  task automatic serveTxn3(input string tag, input int id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] y);
    #1 checkOutput({tag, "_ready"}, 64'(bus3.req_ready), 64'(1 << id));
    @(negedge clk);
    bus3.req_valid[id]    = 1'b0;
    bus3.req_a[id*W +: W] = 32'hDEAD_BEEF;
    bus3.req_b[id*W +: W] = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      #1 checkOutput({tag, "_hold_a"}, 64'(mul_a3), 64'(a));
      checkOutput({tag, "_hold_b"}, 64'(mul_b3), 64'(b));
      checkOutput({tag, "_early"}, 64'(bus3.resp_valid), 64'd0);
      @(negedge clk);
    end
    #1 checkOutput({tag, "_rvalid"}, 64'(bus3.resp_valid), 64'(1 << id));
    checkOutput({tag, "_y"}, 64'(bus3.resp_y), 64'(y));
    bus3.resp_ready = '1;
    @(negedge clk);
    #1 checkOutput({tag, "_busy_end"}, 64'(busy3), 64'd0);
    bus3.resp_ready = '0;
  endtask

  task automatic resetDuts();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus0.req_valid = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.resp_ready = '0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.resp_ready = '0;

    // Reset values, including req_ready held low despite a pending request.
    repeat (2) @(negedge clk);
    bus0.req_valid = 4'b0001;
    #1 checkOutput("rst_ready", 64'(bus0.req_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy0), 64'd0);
    checkOutput("rst_gid", 64'(grant_id0), 64'd0);
    checkOutput("rst_mul_a", 64'(mul_a0), 64'd0);
    checkOutput("rst_rvalid", 64'(bus0.resp_valid), 64'd0);
    checkOutput("rst_y", 64'(bus0.resp_y), 64'd0);
    bus0.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single requester 2: 7 * 6.
    applyStimulus(1'b0, 4'b0100, 2, 32'd7, 32'd6);
    #1 checkOutput("t1_ready", 64'(bus0.req_ready), 64'b0100);
    checkOutput("t1_idle_busy", 64'(busy0), 64'd0);
    @(negedge clk);
    bus0.req_valid = '0;
    #1 checkOutput("t1_busy", 64'(busy0), 64'd1);
    checkOutput("t1_mul_a", 64'(mul_a0), 64'd7);
    checkOutput("t1_mul_b", 64'(mul_b0), 64'd6);
    checkOutput("t1_gid", 64'(grant_id0), 64'd2);
    checkOutput("t1_no_resp", 64'(bus0.resp_valid), 64'd0);
    @(negedge clk);
    #1 checkOutput("t1_rvalid", 64'(bus0.resp_valid), 64'b0100);
    checkOutput("t1_y", 64'(bus0.resp_y), 64'd42);
    bus0.resp_ready = 4'b0100;
    @(negedge clk);
    #1 checkOutput("t1_busy_end", 64'(busy0), 64'd0);
    checkOutput("t1_rvalid_end", 64'(bus0.resp_valid), 64'd0);
    bus0.resp_ready = '0;

    // Request withdrawn before a handshake edge leaves no side effect.
    @(negedge clk);
    bus0.req_valid = 4'b1000;
    #1 checkOutput("drop_ready", 64'(bus0.req_ready), 64'b1000);
    bus0.req_valid = '0;
    #1 checkOutput("drop_ready_off", 64'(bus0.req_ready), 64'd0);
    @(negedge clk);
    #1 checkOutput("drop_busy", 64'(busy0), 64'd0);
    checkOutput("drop_gid", 64'(grant_id0), 64'd2);

    // All four simultaneously after reset: grants 0..3, products i+1 times 10.
    resetDuts();
    for (int i = 0; i < N; i++) applyStimulus(1'b0, 4'b1111, i, 32'(i + 1), 32'd10);
    bus0.resp_ready = '1;
    prev_cycle = cycle_count;
    for (int t = 0; t < N; t++) begin
      serveTxn0("t2", t, 32'((t + 1) * 10));
      checkOutput("t2_period", 64'(cycle_count - prev_cycle), 64'd3);
      prev_cycle = cycle_count;
    end

    // Wrap: last served is 3, requests from 0 and 3.
    applyStimulus(1'b0, 4'b1001, 0, 32'd5, 32'd5);
    applyStimulus(1'b0, 4'b1001, 3, 32'd6, 32'd7);
    serveTxn0("t3_first", 0, 32'd25);
    serveTxn0("t3_second", 3, 32'd42);

    // Back-pressure on requester 1 while requester 2 waits.
    bus0.resp_ready = '0;
    applyStimulus(1'b0, 4'b0110, 1, 32'd11, 32'd13);
    applyStimulus(1'b0, 4'b0110, 2, 32'd2, 32'd21);
    #1 checkOutput("t4_ready", 64'(bus0.req_ready), 64'b0010);
    @(negedge clk);
    bus0.req_valid[1] = 1'b0;
    @(negedge clk);
    #1 checkOutput("t4_rvalid", 64'(bus0.resp_valid), 64'b0010);
    checkOutput("t4_y", 64'(bus0.resp_y), 64'd143);
    bus0.resp_ready = 4'b1101;
    repeat (5) begin
      @(negedge clk);
      #1 checkOutput("t4_hold_y", 64'(bus0.resp_y), 64'd143);
      checkOutput("t4_hold_rvalid", 64'(bus0.resp_valid), 64'b0010);
      checkOutput("t4_no_ready", 64'(bus0.req_ready), 64'd0);
      checkOutput("t4_busy", 64'(busy0), 64'd1);
    end
    bus0.resp_ready = '1;
    @(negedge clk);
    serveTxn0("t4_next", 2, 32'd42);
    bus0.resp_ready = '0;

    // Pipelined multiplier, latency 3: 100 * 3.
    applyStimulus(1'b1, 4'b0001, 0, 32'd100, 32'd3);
    serveTxn3("t5", 0, 32'd100, 32'd3, 32'd300);

    // Reset in MUL discards requester 1's transaction; it is granted again afterwards.
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 1, 32'd9, 32'd5);
    #1 checkOutput("t6_ready", 64'(bus3.req_ready), 64'b0010);
    @(negedge clk);
    #1 checkOutput("t6_in_mul", 64'(busy3), 64'd1);
    rst = 1'b0;
    #1 checkOutput("t6_busy", 64'(busy3), 64'd0);
    checkOutput("t6_mul_a", 64'(mul_a3), 64'd0);
    checkOutput("t6_mul_b", 64'(mul_b3), 64'd0);
    checkOutput("t6_gid", 64'(grant_id3), 64'd0);
    checkOutput("t6_rvalid", 64'(bus3.resp_valid), 64'd0);
    checkOutput("t6_y", 64'(bus3.resp_y), 64'd0);
    checkOutput("t6_ready_rst", 64'(bus3.req_ready), 64'd0);
    @(negedge clk);
    #1 checkOutput("t6_no_stale", 64'(bus3.resp_valid), 64'd0);
    rst = 1'b1;
    serveTxn3("t6_regrant", 1, 32'd9, 32'd5, 32'd45);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one multiplier instance between N_REQ independent requesters.
- Each requester uses a valid/ready request channel (operands A, B) and a valid/ready response channel (product Y).
- Round-robin arbitration, one transaction in flight at a time.
- Supports a combinational multiplier or a pipelined one with fixed latency MUL_LAT.
- Sits between the test/driver interfaces and the multiplier; the multiplier itself is instantiated outside and connected via mul_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand width and product width in bits.
- MUL_LAT, 0, multiplier latency in clock cycles: 0 = combinational; k = product is valid k cycles after operands are applied.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accepted (one-hot or zero).
- req_a  in  N_REQ*WIDTH  operand A, slice i belongs to requester i.
- req_b  in  N_REQ*WIDTH  operand B, slice i belongs to requester i.
- resp_valid  out  N_REQ  per-requester response valid (one-hot or zero).
- resp_ready  in  N_REQ  per-requester response accept.
- resp_y  out  WIDTH  product, shared by all requesters, meaningful only where resp_valid is set.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_y  in  WIDTH  product from the multiplier.
- grant_id  out  $clog2(N_REQ)  index of the current owner.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_grant=N_REQ-1 (requester 0 has first priority).
  - resp_valid=0, resp_y=0, mul_a=0, mul_b=0, grant_id=0, busy=0, latency counter=0.
  - req_ready=0 while reset is asserted.
- States: IDLE, MUL, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching (last_grant+1) mod N_REQ upward with wrap-around.
  - req_ready is combinational: req_ready[winner]=1 in IDLE only; all other bits 0. No valid request gives req_ready=0.
  - Handshake cycle: capture req_a/req_b slice of the winner into mul_a/mul_b, grant_id<=winner, counter<=MUL_LAT, go to MUL.
- MUL:
  - mul_a/mul_b are held stable.
  - counter!=0: decrement.
  - counter==0: resp_y<=mul_y, resp_valid[grant_id]<=1, go to RESP.
  - Latency from request handshake to resp_valid is MUL_LAT+2 cycles.
- RESP:
  - resp_valid and resp_y are held until resp_ready[grant_id]=1.
  - On that edge: resp_valid<=0, last_grant<=grant_id, go to IDLE.
  - resp_ready bits of non-owners are ignored.
- Throughput: one transaction per MUL_LAT+3 cycles minimum (with resp_ready tied high).
- Simultaneous requests: exactly one is granted. The others wait and keep their operands stable (valid/ready rule: once req_valid is asserted it stays high until ready).
- Fairness: the requester just served has lowest priority next round. No requester waits more than N_REQ-1 transactions.
- req_valid dropping in IDLE before the handshake: no grant to that requester; no side effect.
- Reset mid-operation: the in-flight transaction is discarded, no response is issued, and the state returns to its reset values immediately.
- Product width: mul_y is taken as-is, WIDTH bits. Truncation and format are the multiplier's concern.

Decomposition:
- Package mult_arb_pkg:
  - state enum typedef (IDLE, MUL, RESP, 2-bit).
  - default constants for N_REQ, WIDTH, MUL_LAT.
  - function rr_pick(valid vector, last index) returning the winner index plus a found flag.
- Sub-module rr_arbiter, natural and reusable:
  - Inputs: valid vector, last_grant, enable.
  - Outputs: one-hot grant and index. Purely combinational.
- The FSM, counter and datapath registers stay in mult_arbiter.

Test Plan:
1. Single requester, MUL_LAT=0: req 2 sends A=7, B=6 -> req_ready[2] high in the IDLE cycle; resp_valid[2] two cycles later with resp_y=42; busy low after resp_ready.
2. All four request simultaneously after reset, resp_ready tied 1, operands A=i+1, B=10 -> grants in order 0,1,2,3 with products 10,20,30,40; each response 3 cycles apart.
3. Round-robin wrap: last served is 3, requests from 0 and 3 -> 0 is granted first, then 3.
4. Back-pressure: resp_ready[1]=0 for 5 cycles after resp_valid[1] -> resp_y stays constant, no new req_ready asserted, and the state stays RESP until resp_ready[1]=1.
5. MUL_LAT=3 with a pipelined multiplier model: A=100, B=3 -> mul_a/mul_b stable for 4 cycles; resp_valid at handshake+5 with resp_y=300.
6. Reset asserted while in MUL for requester 1 -> all outputs are at reset values on the same edge; after release, requester 1's pending request is re-granted and no stale response appears.
